// File: rtl/sdpram_stream_reader.sv
// Read side of a simple dual-port RAM used as a circular buffer: issues port-B
// reads, absorbs the fixed read latency and presents the words as a valid/ready stream.
module sdpram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_SIZE   = 1024,
    parameter int LATENCY    = 1,
    parameter int BUF_DEPTH  = LATENCY + 1,
    localparam int AW        = $clog2(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [AW:0]           wr_ptr_i,
    output logic [AW:0]           rd_ptr_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic                  ram_re_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o
);

    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [AW:0]           iss_q;
    logic [LATENCY-1:0]    v_q;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [IW-1:0]         wr_idx_q;
    logic [IW-1:0]         rd_idx_q;
    logic [CW-1:0]         cnt_q;

    logic avail;
    logic credit;
    logic push;
    logic pop;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    // A word popped this cycle frees its slot before any new read can land,
    // so it is credited back immediately; that is what sustains 1 word/cycle.
    always_comb begin
        avail    = (wr_ptr_i != iss_q);
        pop      = m_valid_o & m_ready_i & ~flush_i;
        push     = v_q[LATENCY-1] & ~flush_i;
        credit   = (int'(cnt_q) + $countones(v_q) - int'(pop)) < BUF_DEPTH;
        ram_re_o = avail & credit & ~flush_i & ~rst;
    end

    assign ram_addr_o = iss_q[AW-1:0];
    assign m_valid_o  = (cnt_q != '0);
    assign m_data_o   = mem_q[rd_idx_q];

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_q    <= '0;
            rd_ptr_o <= '0;
            v_q      <= '0;
            cnt_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else if (flush_i) begin
            iss_q    <= wr_ptr_i;
            rd_ptr_o <= wr_ptr_i;
            v_q      <= '0;
            cnt_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (ram_re_o) iss_q <= iss_q + 1'b1;
            v_q[0] <= ram_re_o;
            for (int i = 1; i < LATENCY; i++) v_q[i] <= v_q[i-1];
            if (push) wr_idx_q <= next_idx(wr_idx_q);
            if (pop) begin
                rd_idx_q <= next_idx(rd_idx_q);
                rd_ptr_o <= rd_ptr_o + 1'b1;
            end
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; cnt_q alone decides which entries are
    // meaningful, which keeps the array free of reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx_q] <= ram_data_i;
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && cnt_q == CW'(BUF_DEPTH)));

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Directed bench for sdpram_stream_reader: three instances cover latency 1 with a
// large RAM, a 4-word wrapping RAM, and latency 3 with a 4-entry skid FIFO.
module tb_sdpram_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instance A: RAM_SIZE=1024, LATENCY=1
    logic        a_flush, a_re, a_valid, a_ready;
    logic [10:0] a_wr, a_rd;
    logic [9:0]  a_addr;
    logic [31:0] a_rdata, a_data;
    logic [31:0] mem_a [1024];
    logic [31:0] a_out [$];
    logic [9:0]  a_re_addr [$];
    int          a_re_cyc [$];

    sdpram_stream_reader #(.DATA_WIDTH(32), .RAM_SIZE(1024), .LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .flush_i(a_flush), .wr_ptr_i(a_wr), .rd_ptr_o(a_rd),
        .ram_addr_o(a_addr), .ram_re_o(a_re), .ram_data_i(a_rdata),
        .m_valid_o(a_valid), .m_ready_i(a_ready), .m_data_o(a_data));

    always @(posedge clk) if (a_re) a_rdata <= mem_a[a_addr];

    // Instance B: RAM_SIZE=4, LATENCY=1
    logic        b_flush, b_re, b_valid, b_ready;
    logic [2:0]  b_wr, b_rd;
    logic [1:0]  b_addr;
    logic [31:0] b_rdata, b_data;
    logic [31:0] mem_b [4];
    logic [31:0] b_out [$];
    logic [1:0]  b_re_addr [$];
    logic [2:0]  b_prev_rd = '0;
    logic        b_wrap = 1'b0;

    sdpram_stream_reader #(.DATA_WIDTH(32), .RAM_SIZE(4), .LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .flush_i(b_flush), .wr_ptr_i(b_wr), .rd_ptr_o(b_rd),
        .ram_addr_o(b_addr), .ram_re_o(b_re), .ram_data_i(b_rdata),
        .m_valid_o(b_valid), .m_ready_i(b_ready), .m_data_o(b_data));

    always @(posedge clk) if (b_re) b_rdata <= mem_b[b_addr];

    // Instance C: RAM_SIZE=32, LATENCY=3, BUF_DEPTH=4
    logic        c_flush, c_re, c_valid, c_ready;
    logic [5:0]  c_wr, c_rd;
    logic [4:0]  c_addr;
    logic [31:0] c_p0, c_p1, c_rdata, c_data;
    logic [31:0] mem_c [32];
    logic [31:0] c_out [$];
    int          c_re_cyc [$];
    int          c_pop_cyc [$];

    sdpram_stream_reader #(.DATA_WIDTH(32), .RAM_SIZE(32), .LATENCY(3), .BUF_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .flush_i(c_flush), .wr_ptr_i(c_wr), .rd_ptr_o(c_rd),
        .ram_addr_o(c_addr), .ram_re_o(c_re), .ram_data_i(c_rdata),
        .m_valid_o(c_valid), .m_ready_i(c_ready), .m_data_o(c_data));

    always @(posedge clk) begin
        c_p0    <= mem_c[c_addr];
        c_p1    <= c_p0;
        c_rdata <= c_p1;
    end

    // Observers sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_re) begin
                a_re_addr.push_back(a_addr);
                a_re_cyc.push_back(cyc);
            end
            if (a_valid && a_ready) a_out.push_back(a_data);
            if (b_re) b_re_addr.push_back(b_addr);
            if (b_valid && b_ready) b_out.push_back(b_data);
            if (c_re) c_re_cyc.push_back(cyc);
            if (c_valid && c_ready) begin
                c_out.push_back(c_data);
                c_pop_cyc.push_back(cyc);
            end
        end
        if (b_prev_rd == 3'd7 && b_rd == 3'd0) b_wrap = 1'b1;
        b_prev_rd = b_rd;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        a_out.delete(); a_re_addr.delete(); a_re_cyc.delete();
        b_out.delete(); b_re_addr.delete();
        c_out.delete(); c_re_cyc.delete(); c_pop_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_wr = '0; b_wr = '0; c_wr = '0;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0; c_flush = 1'b0;
        tick(2);
        rst = 1'b0;
        clear_queues();
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        int bad;
        int k;
        logic [2:0] diff;

        for (int i = 0; i < 1024; i++) mem_a[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem_a[i] = 32'h100 + i;
        for (int i = 0; i < 4; i++) mem_b[i] = 32'h0;
        for (int i = 0; i < 32; i++) mem_c[i] = 32'h300 + i;
        a_wr = '0; b_wr = '0; c_wr = '0;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        a_flush = 1'b0; b_flush = 1'b0; c_flush = 1'b0;

        do_reset();
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_re", 32'(a_re), 32'd0);
        check("rst_rd_ptr", 32'(a_rd), 32'd0);
        check("rst_addr", 32'(a_addr), 32'd0);

        // Streaming burst of 8 words with the consumer always ready.
        a_wr = 11'd8;
        a_ready = 1'b1;
        t0 = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid) begin
                lat = cyc - t0;
                break;
            end
        end
        check("burst_first_valid_latency", 32'(lat), 32'd2);
        tick(15);
        check("burst_out_count", 32'(a_out.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("burst_data%0d", i), (a_out.size() > i) ? a_out[i] : 32'hdeadbeef, 32'h100 + i);
        check("burst_re_count", 32'(a_re_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("burst_addr%0d", i), (a_re_addr.size() > i) ? 32'(a_re_addr[i]) : 32'hdeadbeef, 32'(i));
        check("burst_re_back_to_back", (a_re_cyc.size() == 8) ? 32'(a_re_cyc[7] - a_re_cyc[0]) : 32'hffffffff, 32'd7);
        check("burst_rd_ptr", 32'(a_rd), 32'd8);

        // Back-pressure: consumer stalled for 10 cycles.
        do_reset();
        a_wr = 11'd8;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_valid && a_data !== 32'h100) bad++;
            tick(1);
        end
        check("bp_reads_while_stalled", 32'(a_re_addr.size()), 32'd2);
        check("bp_valid_held", 32'(a_valid), 32'd1);
        check("bp_data_stable", 32'(bad), 32'd0);
        check("bp_head_data", a_data, 32'h100);
        a_ready = 1'b1;
        tick(15);
        check("bp_out_count", 32'(a_out.size()), 32'd8);
        bad = 0;
        for (int i = 0; i < a_out.size(); i++) if (a_out[i] !== 32'h100 + i) bad++;
        check("bp_data_order", 32'(bad), 32'd0);
        check("bp_rd_ptr", 32'(a_rd), 32'd8);

        // Flush one cycle after two reads were issued.
        do_reset();
        a_wr = 11'd6;
        tick(2);
        a_flush = 1'b1;
        @(negedge clk);
        check("flush_issued_before", 32'(a_re_addr.size()), 32'd2);
        check("flush_re_low", 32'(a_re), 32'd0);
        tick(1);
        a_flush = 1'b0;
        check("flush_valid_low", 32'(a_valid), 32'd0);
        check("flush_rd_ptr", 32'(a_rd), 32'd6);
        check("flush_iss_addr", 32'(a_addr), 32'd6);
        a_ready = 1'b1;
        tick(4);
        check("flush_dropped", 32'(a_out.size()), 32'd0);
        mem_a[6] = 32'habc;
        a_wr = 11'd7;
        tick(6);
        check("flush_next_count", 32'(a_out.size()), 32'd1);
        check("flush_next_data", (a_out.size() > 0) ? a_out[0] : 32'hdeadbeef, 32'habc);
        check("flush_next_rd_ptr", 32'(a_rd), 32'd7);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 8; i++) mem_a[i] = 32'h100 + i;
        do_reset();
        a_wr = 11'd8;
        a_ready = 1'b1;
        tick(3);
        check("arst_pre_valid", 32'(a_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(a_valid), 32'd0);
        check("arst_re", 32'(a_re), 32'd0);
        check("arst_rd_ptr", 32'(a_rd), 32'd0);
        check("arst_addr", 32'(a_addr), 32'd0);
        tick(1);
        a_wr = '0;
        rst = 1'b0;
        clear_queues();
        tick(6);
        check("arst_no_output", 32'(a_out.size()), 32'd0);
        check("arst_valid_after", 32'(a_valid), 32'd0);

        // 4-word RAM, 12 words streamed with wrap and toggling ready.
        do_reset();
        b_wrap = 1'b0;
        k = 0;
        for (int t = 0; t < 300 && b_out.size() < 12; t++) begin
            diff = 3'(k) - b_rd;
            if (k < 12 && diff < 3'd4) begin
                mem_b[k % 4] = 32'h200 + k;
                k++;
                b_wr = 3'(k);
            end
            b_ready = t[0];
            tick(1);
        end
        tick(4);
        check("wrap_out_count", 32'(b_out.size()), 32'd12);
        bad = 0;
        for (int i = 0; i < b_out.size(); i++) if (b_out[i] !== 32'h200 + i) bad++;
        check("wrap_data_order", 32'(bad), 32'd0);
        check("wrap_re_count", 32'(b_re_addr.size()), 32'd12);
        bad = 0;
        for (int i = 0; i < b_re_addr.size(); i++) if (32'(b_re_addr[i]) !== 32'(i % 4)) bad++;
        check("wrap_addr_cycle", 32'(bad), 32'd0);
        check("wrap_rd_ptr_wrapped", 32'(b_wrap), 32'd1);
        check("wrap_rd_ptr_final", 32'(b_rd), 32'd4);

        // Latency 3: 16 words at one word per cycle after the fill.
        do_reset();
        c_wr = 6'd16;
        c_ready = 1'b1;
        t0 = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_valid) begin
                lat = cyc - t0;
                break;
            end
        end
        check("lat3_first_valid_latency", 32'(lat), 32'd4);
        tick(25);
        check("lat3_out_count", 32'(c_out.size()), 32'd16);
        bad = 0;
        for (int i = 0; i < c_out.size(); i++) if (c_out[i] !== 32'h300 + i) bad++;
        check("lat3_data_order", 32'(bad), 32'd0);
        check("lat3_re_back_to_back", (c_re_cyc.size() == 16) ? 32'(c_re_cyc[15] - c_re_cyc[0]) : 32'hffffffff, 32'd15);
        check("lat3_pop_back_to_back", (c_pop_cyc.size() == 16) ? 32'(c_pop_cyc[15] - c_pop_cyc[0]) : 32'hffffffff, 32'd15);
        check("lat3_rd_ptr", 32'(c_rd), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
